program_memory: RTL and testbench

PROGRAM_MEMORY -- requirements
Module: program_memory

---
 rtl/program_memory_pkg.sv | 14 +
 rtl/prog_mem_array.sv | 29 ++
 rtl/program_memory.sv | 152 +++++++++++++++
 tb/tb_program_memory.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/program_memory_pkg.sv
// Shared types and default geometry for the program memory slice.
package program_memory_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } pm_state_t;

    localparam int unsigned PM_DATA_W = 19;
    localparam int unsigned PM_ADDR_W = 12;
    localparam int unsigned PM_DEPTH  = 4096;

endpackage

// File: rtl/prog_mem_array.sv
// Single-port instruction RAM: synchronous write, synchronous read with read enable.
module prog_mem_array #(
    parameter int unsigned DATA_W = 19,
    parameter int unsigned DEPTH  = 4096,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Read data only moves on an enabled read, so it holds between fetches.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/program_memory.sv
// Program memory with a streaming load port and a one-cycle-latency fetch port.
module program_memory
    import program_memory_pkg::*;
#(
    parameter int unsigned DATA_W = PM_DATA_W,
    parameter int unsigned ADDR_W = PM_ADDR_W,
    parameter int unsigned DEPTH  = PM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic              load_overflow,
    output logic [ADDR_W:0]   load_count,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] instruction,
    output logic              instr_valid,
    output logic              fetch_fault,
    output logic [1:0]        state
);

    localparam int unsigned RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] C_LAST  = (ADDR_W+1)'(DEPTH - 1);

    pm_state_t         r_state, w_next;
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic              r_done;
    logic              r_instr_valid;
    logic              r_fault;
    logic              r_instr_loaded;

    logic              w_start_ok, w_start_oor;
    logic              w_accept, w_end_last, w_end_ovf;
    logic              w_fetch_run, w_fetch_ok, w_fetch_bad;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_start_ok  = 1'b0;
        w_start_oor = 1'b0;
        w_accept    = 1'b0;
        w_end_last  = 1'b0;
        w_end_ovf   = 1'b0;
        case (r_state)
            ST_IDLE, ST_RUN: begin
                if (load_start) begin
                    if ({1'b0, load_base} < C_DEPTH) begin
                        w_next     = ST_LOAD;
                        w_start_ok = 1'b1;
                    end else begin
                        w_next      = ST_RUN;
                        w_start_oor = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (load_valid) begin
                    w_accept = 1'b1;
                    if (load_last) begin
                        w_next     = ST_RUN;
                        w_end_last = 1'b1;
                    end else if ({1'b0, r_wptr} == C_LAST) begin
                        w_next    = ST_RUN;
                        w_end_ovf = 1'b1;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_fetch_run = fetch_en && (r_state == ST_RUN);
    assign w_fetch_ok  = w_fetch_run && ({1'b0, fetch_addr} < C_DEPTH);
    assign w_fetch_bad = w_fetch_run && !w_fetch_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr         <= '0;
            r_count        <= '0;
            r_overflow     <= 1'b0;
            r_done         <= 1'b0;
            r_instr_valid  <= 1'b0;
            r_fault        <= 1'b0;
            r_instr_loaded <= 1'b0;
        end else begin
            r_done        <= w_end_last | w_end_ovf | w_start_oor;
            r_instr_valid <= w_fetch_ok;
            r_fault       <= w_fetch_bad;
            if (w_start_ok || w_start_oor) begin
                r_count    <= '0;
                r_overflow <= w_start_oor;
            end
            if (w_start_ok) begin
                r_wptr <= load_base;
            end
            if (w_accept) begin
                r_wptr  <= r_wptr + ADDR_W'(1);
                r_count <= r_count + (ADDR_W+1)'(1);
            end
            if (w_end_ovf) begin
                r_overflow <= 1'b1;
            end
            if (w_fetch_ok) begin
                r_instr_loaded <= 1'b1;
            end
        end
    end

    // Loads and fetches never overlap, so the single RAM port is shared by state.
    assign w_ram_addr = (r_state == ST_LOAD) ? r_wptr : fetch_addr;

    prog_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .i_we    (w_accept),
        .i_re    (w_fetch_ok),
        .i_addr  (w_ram_addr[RAM_AW-1:0]),
        .i_wdata (load_data),
        .o_rdata (w_rdata)
    );

    // RAM read data is not reset; mask it until a fetch has landed since reset.
    assign instruction   = r_instr_loaded ? w_rdata : '0;
    assign load_ready    = (r_state == ST_LOAD);
    assign load_done     = r_done;
    assign load_overflow = r_overflow;
    assign load_count    = r_count;
    assign instr_valid   = r_instr_valid;
    assign fetch_fault   = r_fault;
    assign state         = r_state;

endmodule

// File: tb/tb_program_memory.sv
// Scoreboard bench for program_memory: stimulus queues fetch expectations, monitor checks them.
module tb_program_memory;

    localparam int unsigned DW = 19;
    localparam int unsigned AW = 12;
    localparam int unsigned DP = 16;

    typedef struct packed {
        logic          fault;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic [AW-1:0] load_base;
    logic          load_valid;
    logic [DW-1:0] load_data;
    logic          load_last;
    logic          load_ready;
    logic          load_done;
    logic          load_overflow;
    logic [AW:0]   load_count;
    logic          fetch_en;
    logic [AW-1:0] fetch_addr;
    logic [DW-1:0] instruction;
    logic          instr_valid;
    logic          fetch_fault;
    logic [1:0]    state;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            done_cnt = 0;
    exp_t          sb[$];
    logic [DW-1:0] model [DP];

    program_memory #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .DEPTH  (DP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .load_start    (load_start),
        .load_base     (load_base),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .load_last     (load_last),
        .load_ready    (load_ready),
        .load_done     (load_done),
        .load_overflow (load_overflow),
        .load_count    (load_count),
        .fetch_en      (fetch_en),
        .fetch_addr    (fetch_addr),
        .instruction   (instruction),
        .instr_valid   (instr_valid),
        .fetch_fault   (fetch_fault),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_fetch(input int unsigned addr, input logic fault, input logic [DW-1:0] data);
        exp_t e;
        fetch_en   = 1'b1;
        fetch_addr = AW'(addr);
        e.fault    = fault;
        e.data     = data;
        sb.push_back(e);
    endtask

    // Monitor: every fetch response (valid or fault) must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && load_done) done_cnt++;
        if (!rst && (instr_valid || fetch_fault)) begin
            if (sb.size() == 0) begin
                check("unexpected_response", 32'(instr_valid) << 1 | 32'(fetch_fault), 32'd0);
            end else begin
                e = sb.pop_front();
                check("resp_fault", 32'(fetch_fault), 32'(e.fault));
                check("resp_valid", 32'(instr_valid), 32'(!e.fault));
                check("resp_instruction", 32'(instruction), 32'(e.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; load_start = 1'b0; load_base = '0; load_valid = 1'b0;
        load_data = '0; load_last = 1'b0; fetch_en = 1'b0; fetch_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_ready", 32'(load_ready), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_overflow", 32'(load_overflow), 32'd0);
        check("rst_count", 32'(load_count), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_fault", 32'(fetch_fault), 32'd0);
        check("rst_instruction", 32'(instruction), 32'd0);
        rst = 1'b0;

        // load_valid high in IDLE must not be accepted, nor in the load_start cycle.
        load_valid = 1'b1; load_data = 19'h7FFFF; load_last = 1'b1;
        tick; tick;
        check("idle_state", 32'(state), 32'd0);
        check("idle_ready", 32'(load_ready), 32'd0);
        check("idle_count", 32'(load_count), 32'd0);
        load_start = 1'b1; load_base = 12'd0;
        tick;
        load_start = 1'b0;
        check("enter_load_state", 32'(state), 32'd1);
        check("enter_load_ready", 32'(load_ready), 32'd1);
        check("enter_load_count", 32'(load_count), 32'd0);

        for (int i = 0; i < 10; i++) begin
            load_data = (i % 2 == 0) ? 19'h00006 : 19'h00009;
            load_last = (i == 9);
            model[i]  = load_data;
            tick;
        end
        load_valid = 1'b0; load_last = 1'b0;
        check("load10_state", 32'(state), 32'd2);
        check("load10_count", 32'(load_count), 32'd10);
        check("load10_overflow", 32'(load_overflow), 32'd0);
        check("load10_ready", 32'(load_ready), 32'd0);
        tick;
        check("load10_done_pulses", 32'(done_cnt), 32'd1);

        for (int i = 0; i < 10; i++) begin
            push_fetch(i, 1'b0, model[i]);
            tick;
        end
        fetch_en = 1'b0;
        tick;
        check("idle_fetch_valid", 32'(instr_valid), 32'd0);
        check("hold_instruction", 32'(instruction), 32'h9);
        check("b2b_drained", 32'(sb.size()), 32'd0);

        push_fetch(20, 1'b1, model[9]);
        tick;
        fetch_en = 1'b0;
        check("fault_pulse", 32'(fetch_fault), 32'd1);
        tick;
        check("fault_clears", 32'(fetch_fault), 32'd0);
        push_fetch(16, 1'b1, model[9]);
        tick;
        fetch_en = 1'b0;
        tick;

        // Overflow load: base 14 in a 16-word memory, four beats without last.
        load_start = 1'b1; load_base = 12'd14;
        tick;
        load_start = 1'b0;
        check("ovf_enter_load", 32'(state), 32'd1);
        load_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            load_data = 19'h11111 * DW'(j + 1);
            tick;
        end
        load_valid = 1'b0;
        model[14] = 19'h11111;
        model[15] = 19'h22222;
        check("ovf_state", 32'(state), 32'd2);
        check("ovf_count", 32'(load_count), 32'd2);
        check("ovf_flag", 32'(load_overflow), 32'd1);
        check("ovf_done_pulses", 32'(done_cnt), 32'd2);
        push_fetch(14, 1'b0, model[14]); tick;
        push_fetch(15, 1'b0, model[15]); tick;
        push_fetch(16, 1'b1, model[15]); tick;
        fetch_en = 1'b0;
        tick; tick;

        load_start = 1'b1; load_base = 12'd20;
        tick;
        load_start = 1'b0;
        check("oor_base_state", 32'(state), 32'd2);
        check("oor_base_overflow", 32'(load_overflow), 32'd1);
        check("oor_base_count", 32'(load_count), 32'd0);
        tick;
        check("oor_base_done_pulses", 32'(done_cnt), 32'd3);

        // Reset in the middle of a load: written words persist, later ones are dropped.
        load_start = 1'b1; load_base = 12'd0;
        tick;
        load_start = 1'b0;
        check("mid_enter_load", 32'(state), 32'd1);
        check("mid_overflow_cleared", 32'(load_overflow), 32'd0);
        fetch_en = 1'b1; fetch_addr = 12'd0;
        load_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            load_data = 19'h0A001 + DW'(k);
            model[k]  = load_data;
            tick;
        end
        check("mid_count3", 32'(load_count), 32'd3);
        check("load_fetch_ignored", 32'(instr_valid), 32'd0);
        check("load_fetch_no_fault", 32'(fetch_fault), 32'd0);
        load_data = 19'h0A004;
        #2 rst = 1'b1;
        #1;
        check("async_rst_state", 32'(state), 32'd0);
        check("async_rst_ready", 32'(load_ready), 32'd0);
        check("async_rst_count", 32'(load_count), 32'd0);
        check("async_rst_instruction", 32'(instruction), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; load_valid = 1'b0;
        tick;
        check("post_rst_idle_fetch_valid", 32'(instr_valid), 32'd0);
        check("post_rst_idle_fetch_fault", 32'(fetch_fault), 32'd0);
        fetch_en = 1'b0;
        load_start = 1'b1; load_base = 12'd20;
        tick;
        load_start = 1'b0;
        check("post_rst_run", 32'(state), 32'd2);
        for (int i = 0; i < 4; i++) begin
            push_fetch(i, 1'b0, model[i]);
            tick;
        end
        fetch_en = 1'b0;
        tick; tick;
        check("final_drained", 32'(sb.size()), 32'd0);
        check("final_done_pulses", 32'(done_cnt), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
